// File: rtl/approx_avg_stream.sv
// approx_avg_stream: streaming approximate average over an N-sample window.
// Each accepted sample replaces the oldest window entry and updates a running
// sum. A serial scan then finds the largest entry that does not exceed the
// window mean (N*entry <= sum). The block reports (sum + N*best) >> SHIFT.
// Optional feature: define APPROX_AVG_ROUND_EN to round half-up before the
// shift and saturate the result to the output width. Otherwise the result
// is truncated.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a sample
// SCAN  | one window entry per cycle, tracking the best candidate
// CALC  | register the shifted result
// OUT   | out_valid=1, Y held until out_ready
module approx_avg_stream #(
  parameter int W     = 8,
  parameter int N     = 9,
  parameter int SHIFT = 3,
  localparam int SW   = W + $clog2(N),
  localparam int OW   = SW + 1 - SHIFT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  X,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] Y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          win_full
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(N - 1);
  localparam logic [SW:0]   N_EXT     = (SW + 1)'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  win [N];
  logic [SW-1:0] sum;
  logic [W-1:0]  best;
  logic [IW-1:0] idx;
  logic [IW-1:0] ptr;
  logic [CW-1:0] fill_cnt;

  logic [SW-1:0] sum_next;
  logic [SW:0]   scan_prod;
  logic          scan_take;
  logic [SW:0]   calc_sum;
  logic [OW-1:0] y_next;

  // Running sum stays modular in SW bits; the true window sum always fits.
  assign sum_next = sum + SW'(X) - SW'(win[ptr]);

  // An entry qualifies when it is no larger than the window mean.
  assign scan_prod = N_EXT * (SW + 1)'(win[idx]);
  assign scan_take = (scan_prod <= {1'b0, sum}) && (win[idx] > best);

  assign calc_sum  = {1'b0, sum} + N_EXT * (SW + 1)'(best);

`ifdef APPROX_AVG_ROUND_EN
  localparam logic [SW+1:0] RND_HALF = (SW + 2)'(2 ** (SHIFT - 1));
  localparam logic [SW+1:0] OW_MAX   = (SW + 2)'((2 ** OW) - 1);
  logic [SW+1:0] rnd_sum;
  logic [SW+1:0] rnd_sh;

  // Round half-up, then clamp to what Y can represent.
  always_comb begin
    rnd_sum = {1'b0, calc_sum} + RND_HALF;
    rnd_sh  = rnd_sum >> SHIFT;
    if (rnd_sh > OW_MAX) begin
      y_next = '1;
    end else begin
      y_next = OW'(rnd_sh);
    end
  end
`else
  // Plain truncation of the SW+1-bit intermediate.
  always_comb begin
    y_next = OW'(calc_sum >> SHIFT);
  end
`endif

  // Sequencer: window update, serial scan, result register and handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        win[i] <= '0;
      end
      state     <= IDLE;
      sum       <= '0;
      best      <= '0;
      idx       <= '0;
      ptr       <= '0;
      fill_cnt  <= '0;
      Y         <= '0;
      win_full  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            win[ptr] <= X;
            sum      <= sum_next;
            best     <= '0;
            idx      <= '0;
            ptr      <= (ptr == IDX_LAST) ? '0 : ptr + IW'(1);
            if (!win_full) begin
              fill_cnt <= fill_cnt + CW'(1);
              if (fill_cnt == FILL_LAST) begin
                win_full <= 1'b1;
              end
            end
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (scan_take) begin
            best <= win[idx];
          end
          if (idx == IDX_LAST) begin
            state <= CALC;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        CALC: begin
          Y         <= y_next;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_avg_stream.sv
// Directed bench for approx_avg_stream at W=8, N=9, SHIFT=3.
module tb_approx_avg_stream;

  localparam int W  = 8;
  localparam int N  = 9;
  localparam int SH = 3;
  localparam int OW = W + $clog2(N) + 1 - SH;

`ifdef APPROX_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  X = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] Y;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          win_full;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  approx_avg_stream #(.W(W), .N(N), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .X(X), .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .win_full(win_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         rst;
    logic [7:0] x;
    int         yt;
    int         yr;
    bit         full;
  } vec_t;

  vec_t vecs[30];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sum", int'(dut.sum), 0);
    chk("rst_win_full", int'(win_full), 0);
    chk("rst_y", int'(Y), 0);
  endtask

  // Presents one sample, waits for its result, checks latency, Y and win_full.
  task automatic send(input logic [7:0] x, input int exp_y, input int exp_full, input string nm);
    int k;
    int t_acc;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_ready"}, int'(in_ready), 1);
    X = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t_acc = cyc;
    chk({nm, "_accepted"}, int'(in_ready), 0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, cyc - t_acc, N + 1);
    chk({nm, "_y"}, int'(Y), exp_y);
    chk({nm, "_full"}, int'(win_full), exp_full);
  endtask

  initial begin
    int  k;
    bit  seen;
    vecs[0]  = '{1'b1, 8'd76, 9, 10, 1'b0};
    vecs[1]  = '{1'b1, 8'd10, 1, 1, 1'b0};
    vecs[2]  = '{1'b0, 8'd20, 3, 4, 1'b0};
    vecs[3]  = '{1'b0, 8'd30, 7, 8, 1'b0};
    vecs[4]  = '{1'b0, 8'd40, 23, 24, 1'b0};
    vecs[5]  = '{1'b0, 8'd50, 30, 30, 1'b0};
    vecs[6]  = '{1'b0, 8'd60, 48, 49, 1'b0};
    vecs[7]  = '{1'b0, 8'd70, 68, 69, 1'b0};
    vecs[8]  = '{1'b0, 8'd80, 90, 90, 1'b0};
    vecs[9]  = '{1'b0, 8'd90, 112, 113, 1'b1};
    vecs[10] = '{1'b1, 8'd255, 31, 32, 1'b0};
    vecs[11] = '{1'b0, 8'd255, 63, 64, 1'b0};
    vecs[12] = '{1'b0, 8'd255, 95, 96, 1'b0};
    vecs[13] = '{1'b0, 8'd255, 127, 128, 1'b0};
    vecs[14] = '{1'b0, 8'd255, 159, 159, 1'b0};
    vecs[15] = '{1'b0, 8'd255, 191, 191, 1'b0};
    vecs[16] = '{1'b0, 8'd255, 223, 223, 1'b0};
    vecs[17] = '{1'b0, 8'd255, 255, 255, 1'b0};
    vecs[18] = '{1'b0, 8'd255, 573, 574, 1'b1};
    vecs[19] = '{1'b1, 8'd100, 12, 13, 1'b0};
    vecs[20] = '{1'b0, 8'd100, 25, 25, 1'b0};
    vecs[21] = '{1'b0, 8'd100, 37, 38, 1'b0};
    vecs[22] = '{1'b0, 8'd100, 50, 50, 1'b0};
    vecs[23] = '{1'b0, 8'd100, 62, 63, 1'b0};
    vecs[24] = '{1'b0, 8'd100, 75, 75, 1'b0};
    vecs[25] = '{1'b0, 8'd100, 87, 88, 1'b0};
    vecs[26] = '{1'b0, 8'd100, 100, 100, 1'b0};
    vecs[27] = '{1'b0, 8'd100, 225, 225, 1'b1};
    vecs[28] = '{1'b0, 8'd20, 125, 125, 1'b1};
    vecs[29] = '{1'b0, 8'd20, 115, 115, 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("init_in_ready", int'(in_ready), 1);
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_y", int'(Y), 0);
    chk("init_win_full", int'(win_full), 0);

    for (int j = 0; j < 30; j++) begin
      if (vecs[j].rst) do_reset();
      send(vecs[j].x, RND ? vecs[j].yr : vecs[j].yt, int'(vecs[j].full), $sformatf("vec%0d", j));
      @(negedge clk);
      chk($sformatf("vec%0d_consumed", j), int'(out_valid), 0);
      chk($sformatf("vec%0d_next_ready", j), int'(in_ready), 1);
    end

    // Consumer stalls for five cycles while in_valid pulses are offered.
    do_reset();
    out_ready = 1'b0;
    send(8'd76, RND ? 10 : 9, 0, "stall");
    for (int i = 0; i < 5; i++) begin
      X = 8'd200;
      in_valid = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("stall%0d_y", i), int'(Y), RND ? 10 : 9);
      chk($sformatf("stall%0d_in_ready", i), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    chk("stall_sum", int'(dut.sum), 76);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", int'(out_valid), 0);
    send(8'd8, RND ? 20 : 19, 0, "after_stall");
    @(negedge clk);

    // Reset lands in the middle of a scan.
    do_reset();
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    X = 8'd50;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_sum", int'(dut.sum), 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", int'(seen), 0);
    send(8'd8, 1, 0, "post_abort");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_avg_stream.md
APPROX_AVG_STREAM -- requirements
Module: approx_avg_stream

Interface
REQ-001 SHALL have parameter W, default 8, meaning sample width in bits.
REQ-002 SHALL have parameter N, default 9, meaning window depth in samples (2..64).
REQ-003 SHALL have parameter SHIFT, default 3, meaning the output right-shift amount (1..W).
REQ-004 SHALL derive localparam SW = W+$clog2(N) as the sum width and OW = SW+1-SHIFT as the output width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all flops update on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-007 SHALL have port X, input, W bits, the sample.
REQ-008 SHALL have port in_valid, input, 1 bit, X is valid.
REQ-009 SHALL have port in_ready, output, 1 bit, the block accepts X.
REQ-010 SHALL have port Y, output, OW bits, the approximate-average result.
REQ-011 SHALL have port out_valid, output, 1 bit, Y is valid.
REQ-012 SHALL have port out_ready, input, 1 bit, the consumer takes Y.
REQ-013 SHALL have port win_full, output, 1 bit, N samples accepted since reset.

Function
REQ-014 SHALL hold an N-entry circular window with a write pointer and a running sum (SW bits) that is updated incrementally as sum+X-evicted.
REQ-015 SHALL implement FSM IDLE -> SCAN -> CALC -> OUT -> IDLE.
REQ-016 SHALL drive in_ready=1 only in IDLE; on in_valid&&in_ready the block writes X over the oldest entry, updates sum, clears best and idx, and enters SCAN.
REQ-017 SCAN SHALL examine one entry per cycle (idx 0..N-1): if N*entry<=sum and entry>best, then best<=entry; after idx N-1 the FSM enters CALC.
REQ-018 CALC SHALL register Y=(sum+N*best)>>SHIFT, computed at SW+1 bits, and enter OUT.
REQ-019 OUT SHALL hold out_valid=1 and keep Y stable until out_ready=1, then return to IDLE; out_valid SHALL be 0 in all other states.
REQ-020 Latency: with acceptance at edge E, out_valid SHALL rise at edge E+N+1; with out_ready held high, the next sample SHALL be accepted at edge E+N+3.
REQ-021 in_valid outside IDLE SHALL be ignored with no state change; out_ready outside OUT SHALL have no effect.
REQ-022 Unfilled window entries SHALL count as 0; a result SHALL be produced for every accepted sample, including those before win_full.
REQ-023 win_full SHALL rise on the N-th acceptance after reset and remain 1 until the next reset.
REQ-024 The write pointer SHALL wrap from N-1 to 0; the sum SHALL never overflow SW bits.

Reset
REQ-025 On reset, the block SHALL clear all window entries, sum, best, idx, pointer, fill count, and Y to 0, set win_full=0 and out_valid=0, and set the state to IDLE (in_ready=1).
REQ-026 Reset mid-SCAN/CALC/OUT SHALL abort the operation with no output produced.

Configuration
REQ-027 With macro APPROX_AVG_ROUND_EN defined, Y SHALL be (sum+N*best+2^(SHIFT-1))>>SHIFT, saturated to 2^OW-1; without the macro, Y SHALL be truncated per REQ-018.

Verification (W=8, N=9, SHIFT=3)
REQ-028 Reset, then nine samples of 100 -> ninth Y=225, win_full=1, each out_valid exactly 10 edges after its acceptance.
REQ-029 Reset, then X=76 -> sum=76, best=0, Y=9 (Y=10 with APPROX_AVG_ROUND_EN).
REQ-030 Window 10,20,...,90 -> sum=450, best=50, Y=112 (113 with rounding).
REQ-031 Nine samples of 255 -> Y=573 (574 with rounding); no overflow.
REQ-032 out_ready low for 5 cycles in OUT -> out_valid and Y stable, in_ready=0, in_valid pulses ignored; window unchanged.
REQ-033 Reset asserted in SCAN -> out_valid=0, in_ready=1, sum=0; the next X=8 -> Y=1.
